sram_dp_fifo: RTL and testbench



---
 rtl/sram_pkg.sv | 12 +
 rtl/sram_dp_fifo_if.sv | 18 +
 rtl/sram_dp_model.sv | 22 ++
 rtl/sram_dp_fifo.sv | 88 ++++++++
 tb/tb_sram_dp_fifo.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared constants and types for the dual-port SRAM stream buffer.
package sram_pkg;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] beat_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} rd_state_e;
endpackage

// File: rtl/sram_dp_fifo_if.sv
// Beat stream handshake bundle: producer-side input stream plus consumer-side output stream.
interface sram_dp_fifo_if;
  import sram_pkg::*;

  beat_t sram_in;
  logic  valid_in;
  logic  in_ready;
  beat_t sram_out;
  logic  valid_out;
  logic  out_ready;
  logic  ovf;
  cnt_t  count;

  modport master (output sram_in, valid_in, out_ready,
                  input  in_ready, sram_out, valid_out, ovf, count);
  modport slave  (input  sram_in, valid_in, out_ready,
                  output in_ready, sram_out, valid_out, ovf, count);
endinterface

// File: rtl/sram_dp_model.sv
// Behavioural 1-write/1-read dual-port memory with a registered read port.
module sram_dp_model
  import sram_pkg::*;
(
  input  logic  clk,
  input  logic  i_wr_en,
  input  ptr_t  i_wr_addr,
  input  beat_t i_wr_data,
  input  logic  i_rd_en,
  input  ptr_t  i_rd_addr,
  output beat_t o_rd_data
);
  beat_t r_mem [DEPTH];
  beat_t r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/sram_dp_fifo.sv
// Stream buffer: beats written to SRAM port A, drained from port B through a 2-entry output skid.
module sram_dp_fifo
  import sram_pkg::*;
(
  input logic CLK,
  input logic RST,
  sram_dp_fifo_if.slave bus
);
  ptr_t      r_wr_ptr, r_rd_ptr;
  cnt_t      r_count, w_count_n;
  logic      r_inflight, r_ovf;
  logic [1:0] r_occ, w_occ_n;
  beat_t     r_skid_hd, r_skid_tl, w_rd_data;
  rd_state_e r_state, w_state_n;
  logic      w_in_ready, w_wr, w_pop, w_rd;
  logic      w_hd_from_sram, w_hd_from_tl, w_tl_load;

  assign w_in_ready = ~r_count[ADDR_W];
  assign w_wr       = bus.valid_in & w_in_ready;
  assign w_pop      = (r_occ != 2'd0) & bus.out_ready;

  // STALL means skid plus in-flight already fills both slots; only a pop frees one.
  always_comb begin
    w_rd      = 1'b0;
    w_state_n = r_state;
    case (r_state)
      ISSUE:   w_rd = (r_count != '0);
      STALL:   w_rd = (r_count != '0) && w_pop;
      default: w_rd = 1'b0;
    endcase
    w_count_n = r_count + cnt_t'(w_wr) - cnt_t'(w_rd);
    w_occ_n   = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    if (w_count_n == '0 && !w_rd)
      w_state_n = IDLE;
    else if (w_occ_n == 2'd2 || (w_occ_n == 2'd1 && w_rd))
      w_state_n = STALL;
    else
      w_state_n = ISSUE;
  end

  assign w_hd_from_sram = r_inflight & ((r_occ == 2'd0) | ((r_occ == 2'd1) & w_pop));
  assign w_hd_from_tl   = w_pop & (r_occ == 2'd2);
  assign w_tl_load      = r_inflight & (((r_occ == 2'd1) & ~w_pop) | ((r_occ == 2'd2) & w_pop));

  sram_dp_model u_mem (
    .clk       (CLK),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.sram_in),
    .i_rd_en   (w_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_ovf      <= 1'b0;
      r_state    <= IDLE;
      r_skid_hd  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_n;
      r_inflight <= w_rd;
      r_occ      <= w_occ_n;
      r_state    <= w_state_n;
      if (bus.valid_in & ~w_in_ready) r_ovf <= 1'b1;
      if (w_hd_from_sram)    r_skid_hd <= w_rd_data;
      else if (w_hd_from_tl) r_skid_hd <= r_skid_tl;
    end
  end

  // Tail is pure data and is never observed before being loaded.
  always_ff @(posedge CLK) begin
    if (w_tl_load) r_skid_tl <= w_rd_data;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.sram_out  = r_skid_hd;
  assign bus.valid_out = (r_occ != 2'd0);
  assign bus.ovf       = r_ovf;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_sram_dp_fifo.sv
// Directed bench for sram_dp_fifo: stream, fill/overflow, random backpressure, mid-burst reset.
module tb_sram_dp_fifo;
  import sram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  sram_dp_fifo_if bus();

  sram_dp_fifo dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_pop   = 0;
  beat_t exp_q[$];
  logic  push_exp;
  logic  held;
  beat_t held_v;

  function automatic beat_t pat(input int i);
    return {16{i}};
  endfunction

  task automatic chk(input string tag, input beat_t obs, input beat_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input beat_t d, input logic p);
    bus.valid_in = v;
    bus.sram_in  = d;
    push_exp     = p;
  endtask

  // One clock: score any pop, note stalls, then check the held head after the edge.
  task automatic cyc();
    if (bus.valid_out === 1'b1 && bus.out_ready) begin
      if (exp_q.size() == 0) chk("pop_extra", beat_t'(bus.valid_out), '0);
      else                   chk("pop_data", bus.sram_out, exp_q.pop_front());
      n_pop++;
    end
    held   = (bus.valid_out === 1'b1) && !bus.out_ready;
    held_v = bus.sram_out;
    if (push_exp) exp_q.push_back(bus.sram_in);
    @(posedge clk); #1;
    if (held) begin
      chk("stall_hold_data", bus.sram_out, held_v);
      chk("stall_hold_vld", beat_t'(bus.valid_out), beat_t'(1));
    end
  endtask

  task automatic drain(input int lim);
    for (int c = 0; c < lim && exp_q.size() != 0; c++) cyc();
    chk("drain_empty", beat_t'(exp_q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int pop0;
    rst           = 1'b0;
    bus.valid_in  = 1'b0;
    bus.sram_in   = '0;
    bus.out_ready = 1'b0;
    push_exp      = 1'b0;
    held          = 1'b0;
    held_v        = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", beat_t'(bus.valid_out), '0);
    chk("rst_count", beat_t'(bus.count), '0);
    chk("rst_in_ready", beat_t'(bus.in_ready), beat_t'(1));
    chk("rst_ovf", beat_t'(bus.ovf), '0);
    chk("rst_sram_out", bus.sram_out, '0);
    rst = 1'b0;

    // Back-to-back stream of 64 beats, consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      set_in(1'b1, pat(i), 1'b1);
      cyc();
      if (i == 0) begin
        chk("t1_lat_k_vld", beat_t'(bus.valid_out), '0);
        chk("t1_cnt_first", beat_t'(bus.count), beat_t'(1));
      end
      if (i == 1) begin
        chk("t1_lat_k1_vld", beat_t'(bus.valid_out), '0);
        chk("simul_rw_count", beat_t'(bus.count), beat_t'(1));
        chk("simul_rw_ready", beat_t'(bus.in_ready), beat_t'(1));
      end
      if (i == 2) begin
        chk("t1_lat_k2_vld", beat_t'(bus.valid_out), beat_t'(1));
        chk("t1_first_data", bus.sram_out, pat(0));
      end
    end
    chk("t1_backlog", beat_t'(exp_q.size()), beat_t'(3));
    chk("t1_cnt_end_in", beat_t'(bus.count), beat_t'(1));
    set_in(1'b0, '0, 1'b0);
    drain(20);
    chk("t1_ovf", beat_t'(bus.ovf), '0);
    chk("t1_count_empty", beat_t'(bus.count), '0);
    chk("t1_vld_empty", beat_t'(bus.valid_out), '0);

    // Fill with consumer stalled: two beats sit in the skid, 64 in SRAM, last two dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 68; i++) begin
      set_in(1'b1, pat(100 + i), (i < 66));
      cyc();
      if (i == 63) begin
        chk("t2_cnt_64acc", beat_t'(bus.count), beat_t'(62));
        chk("t2_rdy_64acc", beat_t'(bus.in_ready), beat_t'(1));
      end
      if (i == 65) begin
        chk("t2_cnt_full", beat_t'(bus.count), beat_t'(64));
        chk("t2_rdy_full", beat_t'(bus.in_ready), '0);
        chk("t2_ovf_before", beat_t'(bus.ovf), '0);
      end
      if (i == 66) begin
        chk("t2_ovf_set", beat_t'(bus.ovf), beat_t'(1));
        chk("t2_cnt_drop", beat_t'(bus.count), beat_t'(64));
      end
    end
    set_in(1'b0, '0, 1'b0);
    chk("t2_head", bus.sram_out, pat(100));
    bus.out_ready = 1'b1;
    drain(120);
    chk("t2_count_empty", beat_t'(bus.count), '0);
    chk("t2_ovf_sticky", beat_t'(bus.ovf), beat_t'(1));

    // Random backpressure over 200 beats after clearing ovf with a reset pulse
    rst = 1'b1;
    #1;
    chk("t3_rst_ovf", beat_t'(bus.ovf), '0);
    @(posedge clk); #1;
    rst  = 1'b0;
    sent = 0;
    pop0 = n_pop;
    for (int c = 0; c < 3000 && sent < 200; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (sent - (n_pop - pop0) < 48) begin
        set_in(1'b1, pat(1000 + sent), 1'b1);
        cyc();
        sent++;
      end else begin
        set_in(1'b0, '0, 1'b0);
        cyc();
      end
    end
    chk("t3_sent", beat_t'(sent), beat_t'(200));
    set_in(1'b0, '0, 1'b0);
    bus.out_ready = 1'b1;
    drain(200);
    chk("t3_pops", beat_t'(n_pop - pop0), beat_t'(200));
    chk("t3_ovf", beat_t'(bus.ovf), '0);
    chk("t3_count_empty", beat_t'(bus.count), '0);

    // Asynchronous reset while a read is in flight
    set_in(1'b1, pat(5000), 1'b0);
    cyc();
    set_in(1'b1, pat(5001), 1'b0);
    cyc();
    set_in(1'b0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_vld", beat_t'(bus.valid_out), '0);
    chk("t5_rst_count", beat_t'(bus.count), '0);
    chk("t5_rst_ready", beat_t'(bus.in_ready), beat_t'(1));
    chk("t5_rst_data", bus.sram_out, '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst  = 1'b0;
    pop0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, pat(6000 + i), 1'b1);
      cyc();
    end
    set_in(1'b0, '0, 1'b0);
    drain(20);
    repeat (3) cyc();
    chk("t5_pops", beat_t'(n_pop - pop0), beat_t'(4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
